// File: rtl/reset_sequencer_pkg.sv
// rtl/reset_sequencer_pkg.sv - shared state encoding and sizing helpers for the reset sequencer
//   Contents: FSM state constants/enum, counter-width and domain-index-width helpers.
package reset_sequencer_pkg;

    localparam logic [2:0] ST_ASSERT   = 3'd0;
    localparam logic [2:0] ST_RELEASE  = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_GAP      = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;
    localparam logic [2:0] ST_FAULT    = 3'd5;

    typedef enum logic [2:0] {
        S_ASSERT   = ST_ASSERT,
        S_RELEASE  = ST_RELEASE,
        S_WAIT_ACK = ST_WAIT_ACK,
        S_GAP      = ST_GAP,
        S_DONE     = ST_DONE,
        S_FAULT    = ST_FAULT
    } seq_state_t;

    // Wide enough to hold the largest of the three timing intervals.
    function automatic int seq_cnt_w(input int hold_cycles, input int stage_gap, input int ack_timeout);
        int m;
        m = hold_cycles;
        if (stage_gap > m)   m = stage_gap;
        if (ack_timeout > m) m = ack_timeout;
        return ($clog2(m + 1) > 1) ? $clog2(m + 1) : 1;
    endfunction

    function automatic int domain_idx_w(input int num_domains);
        return (num_domains > 1) ? $clog2(num_domains) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// rtl/reset_sequencer_seq_timer.sv - clearable saturating counter with terminal-count flag
//   clk   : clock
//   rst   : synchronous active-high reset (count to 0)
//   clr   : synchronous clear (load 0)
//   inc   : count enable; holds once the terminal count is reached
//   term  : terminal count value
//   tc    : count == term
module seq_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic [WIDTH-1:0] term,
    output logic             tc
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= '0;
        end else if (inc && !tc) begin
            count <= count + 1'b1;
        end
    end

    assign tc = (count == term);

endmodule

// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - releases NUM_DOMAINS reset domains in index order after system reset
//   target_clk   : sequencer clock
//   target_rst   : synchronous active-high reset
//   sw_rst_req   : restart request, same effect as target_rst
//   domain_ack   : per-domain ready acknowledgement (synchronous)
//   domain_rst   : per-domain reset, active-high, registered
//   seq_done     : all domains released and acknowledged
//   seq_fault    : acknowledgement timeout (or ack loss when monitoring)
//   fault_domain : index of the faulting domain
//   Optional: RESET_SEQUENCER_ACK_MONITOR_EN faults the sequence if any ack drops while DONE.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8,
    parameter int ACK_TIMEOUT = 255
) (
    input  logic                                   target_clk,
    input  logic                                   target_rst,
    input  logic                                   sw_rst_req,
    input  logic [NUM_DOMAINS-1:0]                 domain_ack,
    output logic [NUM_DOMAINS-1:0]                 domain_rst,
    output logic                                   seq_done,
    output logic                                   seq_fault,
    output logic [domain_idx_w(NUM_DOMAINS)-1:0]   fault_domain
);

    localparam int CW = seq_cnt_w(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT);
    localparam int IW = domain_idx_w(NUM_DOMAINS);

    // Each interval ends on the cycle its counter reaches N-1, giving exactly N cycles in the state.
    localparam logic [CW-1:0] HOLD_TC = CW'(HOLD_CYCLES - 1);
    localparam logic [CW-1:0] ACK_TC  = CW'(ACK_TIMEOUT - 1);
    localparam logic [CW-1:0] GAP_TC  = (STAGE_GAP > 0) ? CW'(STAGE_GAP - 1) : '0;
    localparam logic [IW-1:0] LAST_K  = IW'(NUM_DOMAINS - 1);

    seq_state_t      state;
    logic [IW-1:0]   k;
    logic            restart;
    logic            tmr_clr;
    logic            tmr_inc;
    logic [CW-1:0]   tmr_term;
    logic            tmr_tc;

    assign restart = target_rst || sw_rst_req;

    always_comb begin
        tmr_clr  = 1'b0;
        tmr_inc  = 1'b0;
        tmr_term = HOLD_TC;
        case (state)
            S_ASSERT: tmr_inc = 1'b1;
            S_WAIT_ACK: begin
                tmr_term = ACK_TC;
                if (domain_ack[k]) tmr_clr = 1'b1;
                else               tmr_inc = 1'b1;
            end
            S_GAP: begin
                tmr_term = GAP_TC;
                if (tmr_tc) tmr_clr = 1'b1;
                else        tmr_inc = 1'b1;
            end
            default: tmr_clr = 1'b1;
        endcase
    end

    seq_timer #(.WIDTH(CW)) u_timer (
        .clk  (target_clk),
        .rst  (restart),
        .clr  (tmr_clr),
        .inc  (tmr_inc),
        .term (tmr_term),
        .tc   (tmr_tc)
    );

`ifdef RESET_SEQUENCER_ACK_MONITOR_EN
    // Lowest domain whose ack is low, and the mask of that domain and everything above it.
    logic [IW-1:0]          mon_idx;
    logic [NUM_DOMAINS-1:0] mon_mask;
    logic                   mon_hit;

    always_comb begin
        mon_idx  = '0;
        mon_mask = '0;
        mon_hit  = 1'b0;
        for (int i = 0; i < NUM_DOMAINS; i++) begin
            if (!mon_hit && !domain_ack[i]) begin
                mon_hit = 1'b1;
                mon_idx = IW'(i);
            end
            mon_mask[i] = mon_hit;
        end
    end
`endif

    always_ff @(posedge target_clk) begin
        if (restart) begin
            state        <= S_ASSERT;
            k            <= '0;
            domain_rst   <= '1;
            seq_done     <= 1'b0;
            seq_fault    <= 1'b0;
            fault_domain <= '0;
        end else begin
            case (state)
                S_ASSERT: begin
                    if (tmr_tc) state <= S_RELEASE;
                end
                S_RELEASE: begin
                    domain_rst[k] <= 1'b0;
                    state         <= S_WAIT_ACK;
                end
                S_WAIT_ACK: begin
                    if (domain_ack[k]) begin
                        // The last domain goes straight to DONE; no trailing gap.
                        if (k == LAST_K) begin
                            state    <= S_DONE;
                            seq_done <= 1'b1;
                        end else if (STAGE_GAP > 0) begin
                            state <= S_GAP;
                        end else begin
                            k     <= k + 1'b1;
                            state <= S_RELEASE;
                        end
                    end else if (tmr_tc) begin
                        state         <= S_FAULT;
                        seq_fault     <= 1'b1;
                        fault_domain  <= k;
                        domain_rst[k] <= 1'b1;
                    end
                end
                S_GAP: begin
                    if (tmr_tc) begin
                        k     <= k + 1'b1;
                        state <= S_RELEASE;
                    end
                end
                S_DONE: begin
`ifdef RESET_SEQUENCER_ACK_MONITOR_EN
                    if (mon_hit) begin
                        state        <= S_FAULT;
                        seq_done     <= 1'b0;
                        seq_fault    <= 1'b1;
                        fault_domain <= mon_idx;
                        domain_rst   <= domain_rst | mon_mask;
                    end
`endif
                end
                S_FAULT: begin
                end
                default: state <= S_ASSERT;
            endcase
        end
    end

endmodule

// File: doc/reset_sequencer.md
Name: reset_sequencer

Overview:
- Orders the release of NUM_DOMAINS downstream reset domains after the system reset, which has already been synchronized into target_clk.
- Holds all domains in reset, then releases them one at a time in index order.
- After each release, waits for that domain's ready acknowledgement before moving to the next domain.
- Reports completion or timeout fault; supports a software-requested full re-sequence.

Parameters:
NUM_DOMAINS, 4, number of sequenced reset domains (2..16)
HOLD_CYCLES, 16, cycles all domains stay in reset before the first release (>=1)
STAGE_GAP, 8, idle cycles after a domain acks, before the next release (0 = no gap)
ACK_TIMEOUT, 255, max cycles to wait for a domain ack before faulting (>=1)

Ports:
target_clk  input  1  sequencer clock
target_rst  input  1  synchronous active-high reset
sw_rst_req  input  1  one-cycle pulse; restarts the full sequence
domain_ack  input  NUM_DOMAINS  per-domain ready; already synchronous to target_clk
domain_rst  output  NUM_DOMAINS  per-domain reset, active-high, registered
seq_done  output  1  all domains released and acked
seq_fault  output  1  ack timeout occurred
fault_domain  output  $clog2(NUM_DOMAINS)  index of the timed-out domain

Behaviour:
- Interface: one clock target_clk; target_rst is synchronous and active-high.
- All outputs are registered.
- Reset values: domain_rst all 1, seq_done 0, seq_fault 0, fault_domain 0; state ASSERT, stage index k=0, counter 0.
- States: ASSERT, RELEASE, WAIT_ACK, GAP, DONE, FAULT.
- ASSERT:
  - domain_rst all 1; lasts exactly HOLD_CYCLES cycles.
  - domain_rst[0] is seen low exactly HOLD_CYCLES+1 edges after the first edge that samples target_rst=0.
- RELEASE (1 cycle):
  - Clears domain_rst[k]; domains below k stay released.
  - Always goes to WAIT_ACK with the counter cleared.
- WAIT_ACK:
  - Samples domain_ack[k] each cycle.
  - Ack=1: go to GAP if STAGE_GAP>0, otherwise straight to the next stage.
  - An ack already high on entry is accepted in the first cycle.
  - No ack after ACK_TIMEOUT cycles in WAIT_ACK: go to FAULT.
- GAP: lasts STAGE_GAP cycles, then k+1 and RELEASE.
- Next stage when k = NUM_DOMAINS-1: go to DONE.
- DONE: seq_done=1; terminal until target_rst or sw_rst_req.
- FAULT:
  - seq_fault=1, fault_domain=k.
  - domain_rst[k] is re-asserted; domains above k stay asserted; domains below k stay released.
  - Terminal until target_rst or sw_rst_req.
- sw_rst_req in any state: next edge behaves exactly as target_rst (all outputs to reset values, ASSERT, restart HOLD_CYCLES).
- target_rst and sw_rst_req together: identical result.
- sw_rst_req held multiple cycles: sequence stays in ASSERT with the counter held at 0.
- Acks of domains not currently in WAIT_ACK are ignored, unless the optional feature is enabled.
- Counter width: $clog2(max(HOLD_CYCLES, STAGE_GAP, ACK_TIMEOUT)+1); no wrap, saturates at terminal count.

Optional Feature:
- Macro: RESET_SEQUENCER_ACK_MONITOR_EN.
- Defined: in DONE, if any domain_ack drops to 0, the next edge goes to FAULT.
  - fault_domain = lowest index with ack=0.
  - That domain and all higher domains are re-asserted; lower domains stay released.
  - seq_done goes to 0, seq_fault goes to 1.
- Undefined: acks are ignored in DONE.

Decomposition:
- reset_sequencer_pkg holds:
  - the state enum (ASSERT..FAULT);
  - a counter-width function;
  - the DOMAIN_IDX_W constant expression helper.
- One sub-module: seq_timer.
  - Loadable saturating counter with a terminal-count flag.
  - Shared by the ASSERT, WAIT_ACK and GAP timing.

Test Plan:
1. Defaults, all acks tied 1, target_rst high 5 cycles then low -> domain_rst[0] falls 17 edges after release; each subsequent domain falls 1 (RELEASE) + 1 (WAIT_ACK) + 8 (GAP) = 10 edges later; seq_done=1 one cycle after the last WAIT_ACK.
2. domain_ack[2] held 0 -> seq_fault=1, fault_domain=2 after 255 WAIT_ACK cycles; domain_rst=4'b1100; domains 0-1 stay released.
3. From FAULT state, pulse sw_rst_req -> next edge domain_rst=4'b1111, seq_fault=0, seq_done=0; the full sequence repeats.
4. STAGE_GAP=0 with acks arriving 3 cycles after each release -> no GAP cycles; releases spaced RELEASE+WAIT_ACK only.
5. Mid-sequence (k=1 in GAP): assert target_rst and sw_rst_req together -> single clean restart; domain_rst all 1 next edge.
6. With RESET_SEQUENCER_ACK_MONITOR_EN defined, in DONE drop domain_ack[1] -> seq_fault=1, fault_domain=1, domain_rst=4'b1110, seq_done=0.
